// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if
//   Groups the sequencer's control inputs and status outputs into one bundle.
//   The slave modport is the sequencer side and the master modport is the side
//   that drives it (debug controller or testbench).
//   Controls : run, step, halt_req, bp_en, bp_addr, pc, instr_zero
//   Status   : estado, busy, stopped, done, bp_hit, instr_count, cycle_count
interface exec_sequencer_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic             run;
  logic             step;
  logic             halt_req;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  pc;
  logic             instr_zero;
  logic [3:0]       estado;
  logic             busy;
  logic             stopped;
  logic             done;
  logic             bp_hit;
  logic [CNT_W-1:0] instr_count;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output run, step, halt_req, bp_en, bp_addr, pc, instr_zero,
    input  estado, busy, stopped, done, bp_hit, instr_count, cycle_count
  );

  modport slave (
    input  run, step, halt_req, bp_en, bp_addr, pc, instr_zero,
    output estado, busy, stopped, done, bp_hit, instr_count, cycle_count
  );
endinterface

// File: rtl/exec_sequencer.sv
// exec_sequencer
//   Multicycle step controller for the single-issue RISC-V datapath. The 4-bit
//   estado code steers the PC, fetch, decode, control, register-file, ALU and
//   memory units. Adds run/single-step/halt control, a PC breakpoint and
//   saturating retired-instruction and active-cycle counters.
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous reset, active-high
//   ctrl_io  : exec_sequencer_if.slave bundle (controls in, status out)
module exec_sequencer #(
  parameter int PC_W    = 32,
  parameter int CNT_W   = 16,
  parameter int EX_WAIT = 2,
  parameter int WB_WAIT = 2
) (
  input logic              clk,
  input logic              rst,
  exec_sequencer_if.slave  ctrl_io
);

  typedef enum logic [3:0] {
    S_IF      = 4'b0000,
    S_ID      = 4'b0001,
    S_EX      = 4'b0010,
    S_MEM     = 4'b0011,
    S_WB      = 4'b0100,
    S_WAIT_EX = 4'b0101,
    S_WAIT_WB = 4'b0110,
    S_SUMPC   = 4'b1000,
    S_FIM     = 4'b1001,
    S_PAUSE   = 4'b1010,
    S_DISP    = 4'b1100
  } state_e;

  // Wait counters are loaded with N-1 so a hold of N cycles ends when they hit 0.
  localparam logic [3:0] EX_LOAD = 4'((EX_WAIT > 0) ? EX_WAIT - 1 : 0);
  localparam logic [3:0] WB_LOAD = 4'((WB_WAIT > 0) ? WB_WAIT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [3:0]       waitCnt_q, waitCnt_d;
  logic             stepMode_q, stepMode_d;
  logic             haltPend_q, haltPend_d;
  logic             bpSkip_q, bpSkip_d;
  logic             bpHit_q, bpHit_d;
  logic             endFlag_q, endFlag_d;
  logic [CNT_W-1:0] instrCnt_q, instrCnt_d;
  logic [CNT_W-1:0] cycleCnt_q, cycleCnt_d;
  logic             active;
  logic             bpMatch;

  assign active  = (state_q != S_PAUSE) && (state_q != S_FIM);
  // bp_skip lets the instruction that was just resumed from PAUSE fetch past the breakpoint.
  assign bpMatch = ctrl_io.bp_en && (ctrl_io.pc == ctrl_io.bp_addr) && !bpSkip_q;

  // State register: holds the step code plus all sequencing bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_PAUSE;
      waitCnt_q  <= '0;
      stepMode_q <= 1'b0;
      haltPend_q <= 1'b0;
      bpSkip_q   <= 1'b0;
      bpHit_q    <= 1'b0;
      endFlag_q  <= 1'b0;
      instrCnt_q <= '0;
      cycleCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      stepMode_q <= stepMode_d;
      haltPend_q <= haltPend_d;
      bpSkip_q   <= bpSkip_d;
      bpHit_q    <= bpHit_d;
      endFlag_q  <= endFlag_d;
      instrCnt_q <= instrCnt_d;
      cycleCnt_q <= cycleCnt_d;
    end
  end

  // Next-state logic: walks IF..SUMPC, honours run/step/halt only at instruction
  // boundaries (PAUSE and SUMPC), and keeps the counters and flags up to date.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    stepMode_d = stepMode_q;
    haltPend_d = haltPend_q;
    bpSkip_d   = bpSkip_q;
    bpHit_d    = bpHit_q;
    endFlag_d  = endFlag_q;
    instrCnt_d = instrCnt_q;
    cycleCnt_d = cycleCnt_q;

    if (active) begin
      if (cycleCnt_q != CNT_MAX) cycleCnt_d = cycleCnt_q + 1'b1;
      if (ctrl_io.halt_req) haltPend_d = 1'b1;
    end

    unique case (state_q)
      S_PAUSE: begin
        if (ctrl_io.run || ctrl_io.step) begin
          state_d    = S_IF;
          stepMode_d = !ctrl_io.run;
          bpSkip_d   = 1'b1;
          bpHit_d    = 1'b0;
        end
      end
      S_IF: begin
        if (bpMatch) begin
          state_d = S_PAUSE;
          bpHit_d = 1'b1;
        end else begin
          state_d = S_ID;
        end
      end
      S_ID: begin
        if (ctrl_io.instr_zero) begin
          state_d   = S_DISP;
          endFlag_d = 1'b1;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (EX_WAIT == 0) begin
          state_d = S_MEM;
        end else begin
          state_d   = S_WAIT_EX;
          waitCnt_d = EX_LOAD;
        end
      end
      S_WAIT_EX: begin
        if (waitCnt_q == 4'd0) state_d = S_MEM;
        else waitCnt_d = waitCnt_q - 4'd1;
      end
      S_MEM: state_d = S_WB;
      S_WB: begin
        if (WB_WAIT == 0) begin
          state_d = S_DISP;
        end else begin
          state_d   = S_WAIT_WB;
          waitCnt_d = WB_LOAD;
        end
      end
      S_WAIT_WB: begin
        if (waitCnt_q == 4'd0) state_d = S_DISP;
        else waitCnt_d = waitCnt_q - 4'd1;
      end
      S_DISP: state_d = endFlag_q ? S_FIM : S_SUMPC;
      S_SUMPC: begin
        if (instrCnt_q != CNT_MAX) instrCnt_d = instrCnt_q + 1'b1;
        bpSkip_d = 1'b0;
        if (haltPend_q || stepMode_q || !ctrl_io.run) begin
          state_d    = S_PAUSE;
          haltPend_d = 1'b0;
          stepMode_d = 1'b0;
        end else begin
          state_d = S_IF;
        end
      end
      S_FIM: state_d = S_FIM;
      default: state_d = S_PAUSE;
    endcase
  end

  // Output decode: everything comes straight from registers, so no input
  // reaches the status outputs combinationally.
  always_comb begin
    ctrl_io.estado      = state_q;
    ctrl_io.busy        = active;
    ctrl_io.stopped     = (state_q == S_PAUSE);
    ctrl_io.done        = (state_q == S_FIM);
    ctrl_io.bp_hit      = bpHit_q;
    ctrl_io.instr_count = instrCnt_q;
    ctrl_io.cycle_count = cycleCnt_q;
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer
//   Drives two sequencers (16-bit and 4-bit counters) with the same stimulus and
//   compares them every cycle against an instruction-level reference model that
//   keeps the upcoming step codes of the current instruction in a queue.
module tb_exec_sequencer;

  localparam int PC_W  = 32;
  localparam int CNT_W = 16;
  localparam int CNT_S = 4;
  localparam int EXW   = 2;
  localparam int WBW   = 2;
  localparam logic [31:0] BP_ADDR = 32'h10;

  localparam logic [3:0] S_IF      = 4'b0000;
  localparam logic [3:0] S_ID      = 4'b0001;
  localparam logic [3:0] S_EX      = 4'b0010;
  localparam logic [3:0] S_WAIT_EX = 4'b0101;
  localparam logic [3:0] S_MEM     = 4'b0011;
  localparam logic [3:0] S_WB      = 4'b0100;
  localparam logic [3:0] S_WAIT_WB = 4'b0110;
  localparam logic [3:0] S_DISP    = 4'b1100;
  localparam logic [3:0] S_SUMPC   = 4'b1000;
  localparam logic [3:0] S_FIM     = 4'b1001;
  localparam logic [3:0] S_PAUSE   = 4'b1010;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;

  logic [3:0] mState;
  logic [3:0] mQ[$];
  int         mInstr;
  int         mCycle;
  logic       mHalt, mStep, mBpSkip, mBpHit;

  always #5 clk = ~clk;

  exec_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus  ();
  exec_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_S)) bus4 ();

  exec_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W), .EX_WAIT(EXW), .WB_WAIT(WBW)) dut (
    .clk(clk), .rst(rst), .ctrl_io(bus.slave)
  );

  exec_sequencer #(.PC_W(PC_W), .CNT_W(CNT_S), .EX_WAIT(EXW), .WB_WAIT(WBW)) dut4 (
    .clk(clk), .rst(rst), .ctrl_io(bus4.slave)
  );

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic checkValue(input string tag, input string field,
                            input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  // One full instruction after IF, in order.
  task automatic fillInstr();
    mQ.delete();
    mQ.push_back(S_ID);
    mQ.push_back(S_EX);
    for (int i = 0; i < EXW; i++) mQ.push_back(S_WAIT_EX);
    mQ.push_back(S_MEM);
    mQ.push_back(S_WB);
    for (int i = 0; i < WBW; i++) mQ.push_back(S_WAIT_WB);
    mQ.push_back(S_DISP);
    mQ.push_back(S_SUMPC);
  endtask

  task automatic modelReset();
    mState  = S_PAUSE;
    mQ.delete();
    mInstr  = 0;
    mCycle  = 0;
    mHalt   = 1'b0;
    mStep   = 1'b0;
    mBpSkip = 1'b0;
    mBpHit  = 1'b0;
  endtask

  // Advance the model by one clock using the inputs applied for that edge.
  task automatic modelStep(input logic r, input logic s, input logic h,
                           input logic be, input logic [31:0] pcv, input logic iz);
    if (mState != S_PAUSE && mState != S_FIM) begin
      mCycle++;
      if (h) mHalt = 1'b1;
    end
    case (mState)
      S_PAUSE: begin
        if (r || s) begin
          mStep   = !r;
          mBpSkip = 1'b1;
          mBpHit  = 1'b0;
          fillInstr();
          mState  = S_IF;
        end
      end
      S_IF: begin
        if (be && pcv == BP_ADDR && !mBpSkip) begin
          mBpHit = 1'b1;
          mQ.delete();
          mState = S_PAUSE;
        end else begin
          mState = mQ.pop_front();
        end
      end
      S_ID: begin
        if (iz) begin
          mQ.delete();
          mQ.push_back(S_FIM);
          mState = S_DISP;
        end else begin
          mState = mQ.pop_front();
        end
      end
      S_SUMPC: begin
        mInstr++;
        mBpSkip = 1'b0;
        if (mHalt || mStep || !r) begin
          mHalt  = 1'b0;
          mStep  = 1'b0;
          mState = S_PAUSE;
        end else begin
          fillInstr();
          mState = S_IF;
        end
      end
      S_FIM: mState = S_FIM;
      default: mState = mQ.pop_front();
    endcase
  endtask

  task automatic checkOutput(input string tag);
    logic busyExp;
    busyExp = (mState != S_PAUSE) && (mState != S_FIM);
    checkValue(tag, "estado",   32'(bus.estado),      32'(mState));
    checkValue(tag, "busy",     32'(bus.busy),        32'(busyExp));
    checkValue(tag, "stopped",  32'(bus.stopped),     32'(mState == S_PAUSE));
    checkValue(tag, "done",     32'(bus.done),        32'(mState == S_FIM));
    checkValue(tag, "bp_hit",   32'(bus.bp_hit),      32'(mBpHit));
    checkValue(tag, "instr",    32'(bus.instr_count), 32'(sat(mInstr, CNT_W)));
    checkValue(tag, "cycle",    32'(bus.cycle_count), 32'(sat(mCycle, CNT_W)));
    checkValue(tag, "estado4",  32'(bus4.estado),     32'(mState));
    checkValue(tag, "instr4",   32'(bus4.instr_count), 32'(sat(mInstr, CNT_S)));
    checkValue(tag, "cycle4",   32'(bus4.cycle_count), 32'(sat(mCycle, CNT_S)));
  endtask

  // Apply inputs to both DUTs, advance the model, then check after the edge.
  task automatic applyStimulus(input string tag, input logic r, input logic s,
                               input logic h, input logic be,
                               input logic [31:0] pcv, input logic iz);
    bus.run = r;  bus.step = s;  bus.halt_req = h;  bus.bp_en = be;
    bus.pc = pcv; bus.instr_zero = iz; bus.bp_addr = BP_ADDR;
    bus4.run = r; bus4.step = s; bus4.halt_req = h; bus4.bp_en = be;
    bus4.pc = pcv; bus4.instr_zero = iz; bus4.bp_addr = BP_ADDR;
    modelStep(r, s, h, be, pcv, iz);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic runTicks(input string tag, input int n, input logic r,
                          input logic be, input logic [31:0] pcv);
    for (int i = 0; i < n; i++) applyStimulus(tag, r, 1'b0, 1'b0, be, pcv, 1'b0);
  endtask

  // Reset lands mid-cycle so the async path is observed before any clock edge.
  task automatic asyncReset(input string tag);
    #2 rst = 1'b1;
    #1 modelReset();
    checkOutput(tag);
    @(negedge clk);
    rst = 1'b0;
    checkOutput(tag);
  endtask

  initial begin
    logic r, s, h, be, iz;
    logic [31:0] pcv;

    rst = 1'b1;
    bus.run = 0;  bus.step = 0;  bus.halt_req = 0;  bus.bp_en = 0;
    bus.pc = 0;   bus.instr_zero = 0; bus.bp_addr = BP_ADDR;
    bus4.run = 0; bus4.step = 0; bus4.halt_req = 0; bus4.bp_en = 0;
    bus4.pc = 0;  bus4.instr_zero = 0; bus4.bp_addr = BP_ADDR;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset");
    rst = 1'b0;

    // Free run: full step sequence and counters after the first instruction.
    runTicks("run", 12, 1'b1, 1'b0, 32'h20);
    checkValue("run_end", "estado", 32'(bus.estado), 32'(S_IF));
    checkValue("run_end", "instr", 32'(bus.instr_count), 32'd1);
    checkValue("run_end", "cycle", 32'(bus.cycle_count), 32'd11);

    // Drop run: current instruction finishes, then single steps.
    runTicks("stop", 11, 1'b0, 1'b0, 32'h20);
    checkValue("stop_end", "stopped", 32'(bus.stopped), 32'd1);
    checkValue("stop_end", "instr", 32'(bus.instr_count), 32'd2);
    applyStimulus("step1", 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 1'b0);
    runTicks("step1", 11, 1'b0, 1'b0, 32'h20);
    checkValue("step1_end", "instr", 32'(bus.instr_count), 32'd3);
    applyStimulus("step2", 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 1'b0);
    runTicks("step2", 11, 1'b0, 1'b0, 32'h20);
    checkValue("step2_end", "instr", 32'(bus.instr_count), 32'd4);
    checkValue("step2_end", "estado", 32'(bus.estado), 32'(S_PAUSE));

    // Zero instruction: ID -> DISP -> FIM, then terminal.
    applyStimulus("zero", 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 1'b0);
    applyStimulus("zero", 1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 1'b0);
    applyStimulus("zero", 1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 1'b1);
    applyStimulus("zero", 1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 1'b0);
    applyStimulus("fim", 1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 1'b0);
    applyStimulus("fim", 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 1'b0);
    checkValue("fim_end", "done", 32'(bus.done), 32'd1);
    checkValue("fim_end", "instr", 32'(bus.instr_count), 32'd4);
    asyncReset("rst_fim");

    // Breakpoint: skipped on the resumed fetch, hit on the next one.
    runTicks("bp", 12, 1'b1, 1'b1, BP_ADDR);
    applyStimulus("bp", 1'b1, 1'b0, 1'b0, 1'b1, BP_ADDR, 1'b0);
    checkValue("bp_hit", "estado", 32'(bus.estado), 32'(S_PAUSE));
    checkValue("bp_hit", "bp_hit", 32'(bus.bp_hit), 32'd1);
    checkValue("bp_hit", "instr", 32'(bus.instr_count), 32'd1);
    applyStimulus("bp_resume", 1'b1, 1'b0, 1'b0, 1'b1, BP_ADDR, 1'b0);
    checkValue("bp_resume", "bp_hit", 32'(bus.bp_hit), 32'd0);
    runTicks("bp_resume", 11, 1'b1, 1'b1, BP_ADDR);
    checkValue("bp_resume_end", "instr", 32'(bus.instr_count), 32'd2);
    asyncReset("rst_bp");

    // Halt request during EX: instruction completes, then PAUSE.
    runTicks("halt", 3, 1'b1, 1'b0, 32'h20);
    applyStimulus("halt", 1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 1'b0);
    runTicks("halt", 8, 1'b1, 1'b0, 32'h20);
    checkValue("halt_end", "stopped", 32'(bus.stopped), 32'd1);
    checkValue("halt_end", "instr", 32'(bus.instr_count), 32'd1);
    asyncReset("rst_halt");

    // Reset mid-MEM, then saturation of the narrow counters.
    runTicks("mem", 6, 1'b1, 1'b0, 32'h20);
    checkValue("mem", "estado", 32'(bus.estado), 32'(S_MEM));
    asyncReset("rst_mem");
    runTicks("sat", 221, 1'b1, 1'b0, 32'h20);
    checkValue("sat_end", "instr4", 32'(bus4.instr_count), 32'd15);
    checkValue("sat_end", "instr", 32'(bus.instr_count), 32'd20);
    asyncReset("rst_sat");

    // Randomized stretch against the model.
    for (int i = 0; i < 2500; i++) begin
      r   = ($urandom_range(0, 7) != 0);
      s   = ($urandom_range(0, 3) == 0);
      h   = (mState != S_SUMPC) && ($urandom_range(0, 15) == 0);
      be  = ($urandom_range(0, 1) == 1);
      iz  = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 2))
        0:       pcv = BP_ADDR;
        1:       pcv = 32'h14;
        default: pcv = 32'h18;
      endcase
      applyStimulus("rnd", r, s, h, be, pcv, iz);
      if (mState == S_FIM || $urandom_range(0, 299) == 0) asyncReset("rnd_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
